alarm_chime_driver: RTL and testbench

- Sequential consumer of the level Alarm produced by the carWarning family of blocks; turns it into a timed buzzer pattern.
- Pattern: ON/OFF beeps, a beep-count limit, and driver acknowledge/mute.
- Sits between the warning logic and the buzzer pad driver.
- Alarm is treated as asynchronous and is synchronized internally.

---
 rtl/car_warning_pkg.sv | 18 +
 rtl/sync_2ff.sv | 27 ++
 rtl/alarm_chime_driver.sv | 123 ++++++++++++
 tb/tb_alarm_chime_driver.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/car_warning_pkg.sv
// Shared types and default timing for the carWarning family.
// Imported by the chime driver and its helpers.
package car_warning_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BEEP_ON  = 2'd1,
    BEEP_OFF = 2'd2,
    HOLD     = 2'd3
  } chime_state_e;

  localparam int DEF_TICK_DIV  = 1000;
  localparam int DEF_ON_TICKS  = 5;
  localparam int DEF_OFF_TICKS = 5;
  localparam int DEF_MAX_BEEPS = 8;
  localparam int DEF_CW        = 4;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous level inputs.
// Async active-low reset clears both stages.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/alarm_chime_driver.sv
// Turns the synchronized Alarm level into a timed, countable beep
// pattern with driver acknowledge and auto-silence.
module alarm_chime_driver
  import car_warning_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int ON_TICKS  = DEF_ON_TICKS,
  parameter int OFF_TICKS = DEF_OFF_TICKS,
  parameter int MAX_BEEPS = DEF_MAX_BEEPS,
  parameter int CW        = DEF_CW
) (
  input  logic          Clk,
  input  logic          RstN,
  input  logic          Alarm,
  input  logic          Ack,
  output logic          Buzzer,
  output logic          Active,
  output logic          Silenced,
  output logic [CW-1:0] BeepCount
);

  localparam int PMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW   = $clog2(TICK_DIV);
  localparam int PW   = $clog2(PMAX + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] ON_LAST   = PW'(ON_TICKS - 1);
  localparam logic [PW-1:0] OFF_LAST  = PW'(OFF_TICKS - 1);
  localparam logic [CW-1:0] BEEP_MAX  = CW'(MAX_BEEPS);

  logic alarm_s;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk_i  (Clk),
    .rst_ni (RstN),
    .d_i    (Alarm),
    .q_o    (alarm_s)
  );

  chime_state_e  state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [CW-1:0] beep_q, beep_d;
  logic          buzzer_q, active_q, silenced_q;
  logic          tick, run, entry;

  assign tick = (tick_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    beep_d  = beep_q;
    if (!alarm_s) begin
      state_d = IDLE;
      beep_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BEEP_ON;
          beep_d  = CW'(1);
        end
        BEEP_ON: begin
          if (Ack) begin
            state_d = HOLD;
          end else if (tick && phase_q == ON_LAST) begin
            state_d = (beep_q == BEEP_MAX) ? HOLD : BEEP_OFF;
          end
        end
        BEEP_OFF: begin
          if (Ack) begin
            state_d = HOLD;
          end else if (tick && phase_q == OFF_LAST) begin
            state_d = BEEP_ON;
            if (beep_q != BEEP_MAX) beep_d = beep_q + 1'b1;
          end
        end
        HOLD: state_d = HOLD;
        default: state_d = IDLE;
      endcase
    end
  end

  // Timing restarts on every state change so phases are exact multiples.
  always_comb begin
    run   = (state_d == BEEP_ON) || (state_d == BEEP_OFF);
    entry = (state_d != state_q);
    if (!run || entry) begin
      tick_d  = '0;
      phase_d = '0;
    end else if (tick) begin
      tick_d  = '0;
      phase_d = phase_q + 1'b1;
    end else begin
      tick_d  = tick_q + 1'b1;
      phase_d = phase_q;
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      phase_q    <= '0;
      beep_q     <= '0;
      buzzer_q   <= 1'b0;
      active_q   <= 1'b0;
      silenced_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      phase_q    <= phase_d;
      beep_q     <= beep_d;
      buzzer_q   <= (state_d == BEEP_ON);
      active_q   <= (state_d != IDLE);
      silenced_q <= (state_d == HOLD);
    end
  end

  assign Buzzer    = buzzer_q;
  assign Active    = active_q;
  assign Silenced  = silenced_q;
  assign BeepCount = beep_q;

endmodule

// File: tb/tb_alarm_chime_driver.sv
// Randomized and directed bench for alarm_chime_driver against a
// time-based model of the beep pattern.
module tb_alarm_chime_driver;

  localparam int TD   = 4;
  localparam int ONT  = 2;
  localparam int OFFT = 1;
  localparam int MB   = 3;
  localparam int CW   = 4;
  localparam int PER  = (ONT + OFFT) * TD;
  localparam int ONC  = ONT * TD;
  localparam int LIM  = MB * PER - OFFT * TD;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          alarm = 1'b0;
  logic          ack = 1'b0;
  logic          buz, act, sil;
  logic [CW-1:0] bc;
  logic [CW+2:0] obs;

  int checks = 0;
  int failures = 0;

  // Model: sync pipe plus elapsed cycles since the pattern began.
  bit m_s1, m_s2, m_run, m_held;
  int m_t, m_cnt;

  always #5 clk = ~clk;

  alarm_chime_driver #(
    .TICK_DIV  (TD),
    .ON_TICKS  (ONT),
    .OFF_TICKS (OFFT),
    .MAX_BEEPS (MB),
    .CW        (CW)
  ) dut (
    .Clk       (clk),
    .RstN      (rstn),
    .Alarm     (alarm),
    .Ack       (ack),
    .Buzzer    (buz),
    .Active    (act),
    .Silenced  (sil),
    .BeepCount (bc)
  );

  assign obs = {buz, act, sil, bc};

  function automatic logic [CW+2:0] exp_vec();
    logic [CW-1:0] c;
    if (m_run) c = CW'(m_t / PER + 1);
    else if (m_held) c = CW'(m_cnt);
    else c = '0;
    return {m_run && (m_t % PER < ONC), m_run || m_held, m_held, c};
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_run = 0; m_held = 0; m_t = 0; m_cnt = 0;
  endtask

  task automatic model_edge(bit a, bit k);
    if (!m_s2) begin
      m_run = 0; m_held = 0;
    end else if (!m_run && !m_held) begin
      m_run = 1; m_t = 0;
    end else if (m_run) begin
      if (k) begin
        m_held = 1; m_run = 0; m_cnt = m_t / PER + 1;
      end else begin
        m_t++;
        if (m_t >= LIM) begin
          m_held = 1; m_run = 0; m_cnt = MB;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = a;
  endtask

  task automatic step(bit a, bit k);
    alarm = a;
    ack = k;
    @(posedge clk);
    if (rstn) model_edge(a, k);
    else model_reset();
    #1;
  endtask

  task automatic test_reset();
    rstn = 0;
    model_reset();
    repeat (3) step(1, 0);
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0", obs);
    end
    rstn = 1;
    for (int i = 1; i <= 3; i++) begin
      step(1, 0);
      checks++;
      if (buz !== (i == 3) || obs !== exp_vec()) begin
        failures++;
        $display("FAIL reset_release edge=%0d got=%b want_buz=%0d model=%b",
                 i, obs, (i == 3), exp_vec());
      end
    end
  endtask

  task automatic test_full_pattern();
    logic [CW+2:0] want;
    for (int i = 1; i <= 44; i++) begin
      step(1, 0);
      if (i < LIM) want = {i % PER < ONC, 1'b1, 1'b0, CW'(i / PER + 1)};
      else want = {1'b0, 1'b1, 1'b1, CW'(MB)};
      checks++;
      if (obs !== want || obs !== exp_vec()) begin
        failures++;
        $display("FAIL full_pattern cyc=%0d got=%b want=%b", i, obs, want);
      end
    end
  endtask

  task automatic test_ack();
    bit found = 0;
    logic [CW+2:0] held;
    repeat (4) step(0, 0);
    for (int i = 0; i < 60 && !found; i++) begin
      step(1, 0);
      if (m_run && m_t == PER + 3) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL ack_reach_beep2 got=timeout want=second_beep");
    end
    step(1, 1);
    checks++;
    if (buz !== 1'b0 || sil !== 1'b1 || act !== 1'b1 || bc !== CW'(2)) begin
      failures++;
      $display("FAIL ack_hold got=%b want=buz0 act1 sil1 bc2", obs);
    end
    held = obs;
    for (int i = 0; i < 10; i++) begin
      step(1, i[0]);
      checks++;
      if (obs !== held || obs !== exp_vec()) begin
        failures++;
        $display("FAIL ack_repeat cyc=%0d got=%b want=%b", i, obs, held);
      end
    end
  endtask

  task automatic test_alarm_drop();
    repeat (4) step(0, 0);
    repeat (5) step(1, 0);
    step(0, 0);
    step(0, 0);
    checks++;
    if (buz !== 1'b1) begin
      failures++;
      $display("FAIL drop_early got=%b want=1", buz);
    end
    step(0, 0);
    checks++;
    if (buz !== 1'b0 || act !== 1'b0 || bc !== '0 || sil !== 1'b0) begin
      failures++;
      $display("FAIL drop_idle got=%b want=0", obs);
    end
    repeat (3) step(1, 0);
    checks++;
    if (buz !== 1'b1 || bc !== CW'(1)) begin
      failures++;
      $display("FAIL drop_restart got=%b want=buz1 bc1", obs);
    end
    for (int i = 1; i <= ONC; i++) begin
      step(1, 0);
      checks++;
      if (buz !== (i < ONC) || obs !== exp_vec()) begin
        failures++;
        $display("FAIL drop_beep_len cyc=%0d got=%b want_buz=%0d",
                 i, obs, (i < ONC));
      end
    end
  endtask

  task automatic test_simultaneous();
    repeat (4) step(0, 0);
    repeat (4) step(1, 0);
    step(0, 0);
    step(0, 0);
    step(0, 1);
    checks++;
    if (sil !== 1'b0 || act !== 1'b0 || buz !== 1'b0 || obs !== exp_vec()) begin
      failures++;
      $display("FAIL simul_drop_ack got=%b want=0", obs);
    end
    repeat (3) step(1, 0);
    step(1, 1);
    for (int i = 0; i < 30; i++) begin
      step(1, ($urandom_range(0, 3) == 0));
      checks++;
      if (buz !== 1'b0 || sil !== 1'b1 || bc !== CW'(1)) begin
        failures++;
        $display("FAIL hold_no_beep cyc=%0d got=%b want=buz0 sil1 bc1", i, obs);
      end
    end
  endtask

  task automatic test_async_reset();
    repeat (4) step(0, 0);
    repeat (5) step(1, 0);
    #2;
    rstn = 0;
    model_reset();
    #1;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL async_reset got=%b want=0", obs);
    end
    #2;
    rstn = 1;
    for (int i = 1; i <= 3; i++) begin
      step(1, 0);
      checks++;
      if (buz !== (i == 3) || obs !== exp_vec()) begin
        failures++;
        $display("FAIL async_restart edge=%0d got=%b want_buz=%0d",
                 i, obs, (i == 3));
      end
    end
  endtask

  task automatic test_random();
    bit a = 1;
    bit k;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) a = ~a;
      k = ($urandom_range(0, 14) == 0);
      step(a, k);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b want=%b", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_full_pattern();
    test_ack();
    test_alarm_drop();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
